// File: rtl/bin2seg_digits.sv
// ============================================================================
// Module   : bin2seg_digits
// Function : binary -> three 7-segment digits via iterative double dabble
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2seg_digits #(
    parameter int IN_W = 10,
    parameter bit LZB  = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [11:0]     bcd,
    output logic [6:0]      hundreds,
    output logic [6:0]      tens,
    output logic [6:0]      ones
);

    localparam logic [3:0]  c_LAST = 4'(IN_W - 1);
    localparam logic [6:0]  c_DASH = 7'b0000001;
    localparam logic [6:0]  c_BLNK = 7'b0000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_ENC  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_shreg;
    logic [11:0]       r_acc;
    logic [3:0]        r_cnt;
    logic              r_ovf_nxt;
    logic              w_ovf_in;
    logic [10:0]       w_adj;

    logic              r_done;
    logic              r_ovf;
    logic [11:0]       r_bcd;
    logic [6:0]        r_seg_h;
    logic [6:0]        r_seg_t;
    logic [6:0]        r_seg_o;

    logic [3:0]        w_h;
    logic [3:0]        w_t;
    logic [3:0]        w_o;
    logic              w_blank_h;
    logic              w_blank_t;
    logic [6:0]        w_seg_h;
    logic [6:0]        w_seg_t;
    logic [6:0]        w_seg_o;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign w_ovf_in = (32'(bin_in) > 32'd999);

    // Add-3 correction on tens/ones nibbles before each shift.
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                  r_acc[4*gi +: 4] + 4'd3 : r_acc[4*gi +: 4];
    end

    // Only the low three hundreds bits survive the shift; the thousands carry is dropped.
    assign w_adj[10:8] = (r_acc[11:8] >= 4'd5) ? r_acc[10:8] + 3'd3 : r_acc[10:8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CONV;
            S_CONV:  if (r_cnt == c_LAST) w_state_nxt = S_ENC;
            S_ENC:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_shreg   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_nxt <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg   <= bin_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_ovf_nxt <= w_ovf_in;
                    end
                end
                S_CONV: begin
                    r_acc   <= {w_adj, r_shreg[IN_W-1]};
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_h       = r_acc[11:8];
    assign w_t       = r_acc[7:4];
    assign w_o       = r_acc[3:0];
    assign w_blank_h = LZB && (w_h == 4'd0);
    assign w_blank_t = LZB && (w_h == 4'd0) && (w_t == 4'd0);

    always_comb begin
        w_seg_h = w_blank_h ? c_BLNK : f_seg(w_h);
        w_seg_t = w_blank_t ? c_BLNK : f_seg(w_t);
        w_seg_o = f_seg(w_o);
        if (r_ovf_nxt) begin
            w_seg_h = c_DASH;
            w_seg_t = c_DASH;
            w_seg_o = c_DASH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bcd   <= '0;
            r_seg_h <= c_BLNK;
            r_seg_t <= c_BLNK;
            r_seg_o <= c_BLNK;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_ENC) begin
                r_done  <= 1'b1;
                r_ovf   <= r_ovf_nxt;
                r_bcd   <= r_ovf_nxt ? 12'h999 : r_acc;
                r_seg_h <= w_seg_h;
                r_seg_t <= w_seg_t;
                r_seg_o <= w_seg_o;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign ovf      = r_ovf;
    assign bcd      = r_bcd;
    assign hundreds = r_seg_h;
    assign tens     = r_seg_t;
    assign ones     = r_seg_o;

endmodule

`default_nettype wire

// File: tb/tb_bin2seg_digits.sv
// ============================================================================
// Module   : tb_bin2seg_digits
// Function : self-checking bench for bin2seg_digits (LZB=1 and LZB=0 instances)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin2seg_digits;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bin_in = '0;

    logic       busy, done, ovf;
    logic [11:0] bcd;
    logic [6:0] hundreds, tens, ones;
    logic       busy0, done0, ovf0;
    logic [11:0] bcd0;
    logic [6:0] hundreds0, tens0, ones0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0]  h;
        logic [6:0]  t;
        logic [6:0]  o;
        logic [11:0] bcd;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [9:0] v;
        res_t       e;
    } vec_t;

    bin2seg_digits #(.IN_W(10), .LZB(1'b1)) dut (
        .clk(clk), .rstb(rstb), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .ovf(ovf), .bcd(bcd),
        .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    bin2seg_digits #(.IN_W(10), .LZB(1'b0)) dut0 (
        .clk(clk), .rstb(rstb), .start(start), .bin_in(bin_in),
        .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0),
        .hundreds(hundreds0), .tens(tens0), .ones(ones0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return tbl[d];
    endfunction

    function automatic res_t model(input int v, input bit lzb);
        res_t r;
        int hd, td, od;
        if (v > 999) begin
            r.h = 7'b0000001; r.t = 7'b0000001; r.o = 7'b0000001;
            r.bcd = 12'h999; r.ovf = 1'b1;
        end else begin
            hd = v / 100; td = (v / 10) % 10; od = v % 10;
            r.bcd = {hd[3:0], td[3:0], od[3:0]};
            r.h = (lzb && hd == 0) ? 7'b0 : seg_of(hd);
            r.t = (lzb && hd == 0 && td == 0) ? 7'b0 : seg_of(td);
            r.o = seg_of(od);
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    task automatic chk_res(input string tag, input res_t e1, input res_t e0);
        chk({tag, " hundreds"}, 32'(hundreds), 32'(e1.h));
        chk({tag, " tens"}, 32'(tens), 32'(e1.t));
        chk({tag, " ones"}, 32'(ones), 32'(e1.o));
        chk({tag, " bcd"}, 32'(bcd), 32'(e1.bcd));
        chk({tag, " ovf"}, 32'(ovf), 32'(e1.ovf));
        chk({tag, " lzb0 segs"}, 32'({hundreds0, tens0, ones0}), 32'({e0.h, e0.t, e0.o}));
        chk({tag, " lzb0 bcd/ovf"}, 32'({bcd0, ovf0}), 32'({e0.bcd, e0.ovf}));
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [9:0] v, input res_t e1);
        int lat;
        bit bok;
        start = 1'b1; bin_in = v;
        tick;
        start = 1'b0; bin_in = ~v;
        wait_done(lat, bok);
        chk({tag, " latency"}, 32'(lat), 32'd11);
        chk({tag, " busy during conv"}, 32'(bok), 32'd1);
        chk({tag, " done/busy at done"}, 32'({done, busy, done0}), 32'b101);
        chk_res(tag, e1, model(int'(v), 1'b0));
        tick;
        chk({tag, " done single pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t tbl [9];
        int   lat, ndone, dlat;
        bit   bok;
        logic [6:0] cap_h;
        logic [11:0] cap_bcd;
        logic [9:0] rv;

        tbl[0] = '{10'd123,  '{7'h30, 7'h6D, 7'h79, 12'h123, 1'b0}};
        tbl[1] = '{10'd7,    '{7'h00, 7'h00, 7'h70, 12'h007, 1'b0}};
        tbl[2] = '{10'd0,    '{7'h00, 7'h00, 7'h7E, 12'h000, 1'b0}};
        tbl[3] = '{10'd40,   '{7'h00, 7'h33, 7'h7E, 12'h040, 1'b0}};
        tbl[4] = '{10'd1000, '{7'h01, 7'h01, 7'h01, 12'h999, 1'b1}};
        tbl[5] = '{10'd1023, '{7'h01, 7'h01, 7'h01, 12'h999, 1'b1}};
        tbl[6] = '{10'd999,  '{7'h7B, 7'h7B, 7'h7B, 12'h999, 1'b0}};
        tbl[7] = '{10'd456,  '{7'h33, 7'h5B, 7'h5F, 12'h456, 1'b0}};
        tbl[8] = '{10'd42,   '{7'h00, 7'h33, 7'h6D, 12'h042, 1'b0}};

        // reset state, with start asserted to show reset wins
        rstb = 1'b0; start = 1'b1; bin_in = 10'd300;
        tick; tick;
        chk("reset busy/done/ovf", 32'({busy, done, ovf}), 32'd0);
        chk("reset bcd", 32'(bcd), 32'd0);
        chk("reset segs", 32'({hundreds, tens, ones}), 32'd0);
        start = 1'b0; rstb = 1'b1;
        tick;

        foreach (tbl[i]) begin
            run_vec($sformatf("tbl%0d(%0d)", i, tbl[i].v), tbl[i].v, tbl[i].e);
        end

        // outputs hold indefinitely
        repeat (6) tick;
        chk("hold segs", 32'({hundreds, tens, ones}), 32'({7'h00, 7'h33, 7'h6D}));

        // start while busy is ignored
        start = 1'b1; bin_in = 10'd999;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1; bin_in = 10'd5;
        tick;
        start = 1'b0;
        ndone = 0; dlat = -1; lat = 2; cap_h = '0; cap_bcd = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                if (dlat < 0) begin
                    dlat = lat; cap_h = hundreds; cap_bcd = bcd;
                end
            end
            tick;
            lat++;
        end
        chk("busy-start done count", 32'(ndone), 32'd1);
        chk("busy-start latency", 32'(dlat), 32'd11);
        chk("busy-start result", 32'({cap_h, cap_bcd}), 32'({7'h7B, 12'h999}));

        // reset in the middle of a conversion
        start = 1'b1; bin_in = 10'd456;
        tick;
        start = 1'b0;
        repeat (3) tick;
        rstb = 1'b0;
        tick;
        rstb = 1'b1;
        chk("abort busy/done", 32'({busy, done, ovf}), 32'd0);
        chk("abort segs", 32'({hundreds, tens, ones, bcd}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            tick;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        run_vec("after abort 456", 10'd456, tbl[7].e);

        // start held through the done cycle is re-accepted there
        start = 1'b1; bin_in = 10'd42;
        tick;
        wait_done(lat, bok);
        chk("held start latency1", 32'(lat), 32'd11);
        chk_res("held start r1", tbl[8].e, model(42, 1'b0));
        tick;
        start = 1'b0;
        chk("held start re-accepted", 32'(busy), 32'd1);
        wait_done(lat, bok);
        chk("held start latency2", 32'(lat), 32'd11);
        chk("held start busy", 32'(bok), 32'd1);
        chk_res("held start r2", tbl[8].e, model(42, 1'b0));
        tick;

        for (int i = 0; i < 40; i++) begin
            rv = 10'($urandom_range(0, 1023));
            run_vec($sformatf("rand%0d(%0d)", i, rv), rv, model(int'(rv), 1'b1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
